// File: rtl/pim_sched_pkg.sv
// Shared constants and types for the PIM request scheduler: instruction width,
// opcode map and the arbitration mode encoding.
package pim_sched_pkg;

  localparam int REQ_W = 25;

  typedef enum logic [2:0] {
    OP_LD   = 3'd0,
    OP_ST   = 3'd1,
    OP_LDPU = 3'd2,
    OP_STPU = 3'd3,
    OP_LDST = 3'd4,
    OP_PRE  = 3'd5,
    OP_MAC  = 3'd6,
    OP_POOL = 3'd7
  } opcode_e;

  typedef enum logic {
    READ        = 1'b0,
    WRITE_DRAIN = 1'b1
  } mode_e;

  // Which queue, if any, feeds the output register this cycle.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_RD   = 2'd1,
    SEL_WR   = 2'd2
  } sel_e;

endpackage

// File: rtl/pim_req_fifo.sv
// Synchronous FIFO with power-of-two depth; pointers wrap naturally and occupancy
// is held in a separate counter so full and empty are never ambiguous.
module pim_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 25,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: storage is not reset; pointers and count define validity, and a reset
  // on the array would turn it into flops with a large reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement or process order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pim_req_scheduler.sv
// Read/write request scheduler: two FIFO queues, read-priority arbitration with
// watermark and starvation-driven write drain, and a registered valid/ready output.
module pim_req_scheduler #(
  parameter int REQ_W      = pim_sched_pkg::REQ_W,
  parameter int DEPTH      = 4,
  parameter int WR_HIGH    = 3,
  parameter int STARVE_MAX = 8,
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_is_rd,
  input  logic [REQ_W-1:0] req_data,
  output logic             req_ready,
  output logic             ins_valid,
  input  logic             ins_ready,
  output logic [REQ_W-1:0] ins_data,
  output logic             ins_is_rd,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
);

  import pim_sched_pkg::*;

  localparam int ST_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] WR_HIGH_C    = CNT_W'(WR_HIGH);
  localparam logic [ST_W-1:0]  STARVE_MAX_C = ST_W'(STARVE_MAX);

  mode_e            mode, mode_d;
  sel_e             sel;
  logic [ST_W-1:0]  starve_cnt;
  logic             rd_full, rd_empty, wr_full, wr_empty;
  logic [REQ_W-1:0] rd_data, wr_data;
  logic             push_rd, push_wr, pop_rd, pop_wr;
  logic             load_opp, force_drain;

  // Readiness depends only on the target queue's own fullness, never on a same-cycle pop.
  assign req_ready = req_is_rd ? !rd_full : !wr_full;
  assign push_rd   = req_valid && req_ready && req_is_rd;
  assign push_wr   = req_valid && req_ready && !req_is_rd;
  assign pop_rd    = (sel == SEL_RD);
  assign pop_wr    = (sel == SEL_WR);

  pim_req_fifo #(.DEPTH(DEPTH), .WIDTH(REQ_W)) u_rd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_rd),
    .push_data (req_data),
    .pop       (pop_rd),
    .pop_data  (rd_data),
    .count     (rd_count),
    .full      (rd_full),
    .empty     (rd_empty)
  );

  pim_req_fifo #(.DEPTH(DEPTH), .WIDTH(REQ_W)) u_wr_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_wr),
    .push_data (req_data),
    .pop       (pop_wr),
    .pop_data  (wr_data),
    .count     (wr_count),
    .full      (wr_full),
    .empty     (wr_empty)
  );

  assign load_opp    = !ins_valid || ins_ready;
  assign force_drain = (wr_count >= WR_HIGH_C) || ((starve_cnt == STARVE_MAX_C) && !wr_empty);

  // NOTE: every output of this block is given a default first so no path
  // through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    mode_d = mode;
    sel    = SEL_NONE;
    unique case (mode)
      READ: begin
        if (load_opp) begin
          if (force_drain) begin
            sel    = SEL_WR;
            mode_d = WRITE_DRAIN;
          end else if (!rd_empty) begin
            sel = SEL_RD;
          end else if (!wr_empty) begin
            sel = SEL_WR;
          end
        end
      end
      WRITE_DRAIN: begin
        if (!wr_empty) begin
          if (load_opp) sel = SEL_WR;
        end else begin
          // Drain finished: fall back to read service without a bubble.
          mode_d = READ;
          if (load_opp && !rd_empty) sel = SEL_RD;
        end
      end
      default: mode_d = READ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mode <= READ;
    else       mode <= mode_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (pop_wr || wr_empty) begin
      starve_cnt <= '0;
    end else if (pop_rd && (starve_cnt != STARVE_MAX_C)) begin
      starve_cnt <= starve_cnt + ST_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ins_valid <= 1'b0;
      ins_data  <= '0;
      ins_is_rd <= 1'b0;
    end else if (sel != SEL_NONE) begin
      ins_valid <= 1'b1;
      ins_data  <= pop_rd ? rd_data : wr_data;
      ins_is_rd <= pop_rd;
    end else if (ins_ready) begin
      ins_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pim_req_scheduler.sv
// Self-checking bench for pim_req_scheduler: directed scenarios followed by random
// traffic, all compared each cycle against a queue-based behavioural model.
module tb_pim_req_scheduler;

  import pim_sched_pkg::*;

  localparam int DEPTH      = 4;
  localparam int WR_HIGH    = 3;
  localparam int STARVE_MAX = 8;
  localparam int CNT_W      = $clog2(DEPTH) + 1;

  logic             clk;
  logic             reset;
  logic             req_valid;
  logic             req_is_rd;
  logic [REQ_W-1:0] req_data;
  logic             req_ready;
  logic             ins_valid;
  logic             ins_ready;
  logic [REQ_W-1:0] ins_data;
  logic             ins_is_rd;
  logic [CNT_W-1:0] rd_count;
  logic [CNT_W-1:0] wr_count;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: two plain FIFOs plus the issued-instruction register.
  logic [REQ_W-1:0] rq[$];
  logic [REQ_W-1:0] wq[$];
  bit               m_drain;
  int               m_starve;
  bit               m_valid;
  logic [REQ_W-1:0] m_data;
  bit               m_is_rd;

  pim_req_scheduler #(
    .REQ_W(REQ_W), .DEPTH(DEPTH), .WR_HIGH(WR_HIGH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_is_rd (req_is_rd),
    .req_data  (req_data),
    .req_ready (req_ready),
    .ins_valid (ins_valid),
    .ins_ready (ins_ready),
    .ins_data  (ins_data),
    .ins_is_rd (ins_is_rd),
    .rd_count  (rd_count),
    .wr_count  (wr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    rq.delete();
    wq.delete();
    m_drain  = 1'b0;
    m_starve = 0;
    m_valid  = 1'b0;
    m_data   = '0;
    m_is_rd  = 1'b0;
  endfunction

  // One clock edge of the scheduling rules, applied to the queues directly.
  function automatic void model_edge(input bit v, input bit isrd, input logic [REQ_W-1:0] d,
                                     input bit rdy);
    int rs = rq.size();
    int ws = wq.size();
    bit take = !m_valid || rdy;
    bit accept = isrd ? (rs < DEPTH) : (ws < DEPTH);
    bit take_rd = 1'b0;
    bit take_wr = 1'b0;
    if (!m_drain) begin
      if (take) begin
        if (ws >= WR_HIGH || (m_starve == STARVE_MAX && ws > 0)) begin
          take_wr = 1'b1;
          m_drain = 1'b1;
        end else if (rs > 0) take_rd = 1'b1;
        else if (ws > 0)     take_wr = 1'b1;
      end
    end else if (ws > 0) begin
      take_wr = take;
    end else begin
      m_drain = 1'b0;
      take_rd = take && (rs > 0);
    end
    if (take_wr || ws == 0)        m_starve = 0;
    else if (take_rd)              m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
    if (take_rd) begin
      m_data = rq.pop_front(); m_valid = 1'b1; m_is_rd = 1'b1;
    end else if (take_wr) begin
      m_data = wq.pop_front(); m_valid = 1'b1; m_is_rd = 1'b0;
    end else if (take) begin
      m_valid = 1'b0;
    end
    if (v && accept) begin
      if (isrd) rq.push_back(d);
      else      wq.push_back(d);
    end
  endfunction

  task automatic compare_all();
    check("ins_valid", 32'(ins_valid), 32'(m_valid));
    if (m_valid) begin
      check("ins_data", 32'(ins_data), 32'(m_data));
      check("ins_is_rd", 32'(ins_is_rd), 32'(m_is_rd));
    end
    check("rd_count", 32'(rd_count), 32'(rq.size()));
    check("wr_count", 32'(wr_count), 32'(wq.size()));
    check("req_ready", 32'(req_ready),
          32'(req_is_rd ? (rq.size() < DEPTH) : (wq.size() < DEPTH)));
  endtask

  task automatic step(input bit v, input bit isrd, input logic [REQ_W-1:0] d, input bit rdy);
    req_valid = v;
    req_is_rd = isrd;
    req_data  = d;
    ins_ready = rdy;
    @(posedge clk);
    model_edge(v, isrd, d, rdy);
    #1;
    compare_all();
  endtask

  // Asynchronous reset between edges; state must clear without waiting for a clock.
  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check("rst_ins_valid", 32'(ins_valid), 32'd0);
    check("rst_ins_data", 32'(ins_data), 32'd0);
    check("rst_ins_is_rd", 32'(ins_is_rd), 32'd0);
    check("rst_rd_count", 32'(rd_count), 32'd0);
    check("rst_wr_count", 32'(wr_count), 32'd0);
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, '0, 1'b1);
  endtask

  initial begin
    logic [REQ_W-1:0] exp_seq [5];
    req_valid = 1'b0;
    req_is_rd = 1'b0;
    req_data  = '0;
    ins_ready = 1'b0;
    reset     = 1'b0;
    #1;
    apply_reset();

    // Mid-stream reset discards queued and issued reads.
    step(1'b1, 1'b1, 25'h0A0001, 1'b0);
    step(1'b1, 1'b1, 25'h0A0002, 1'b0);
    #2;
    apply_reset();
    step(1'b1, 1'b1, 25'h0A0003, 1'b1);
    step(1'b0, 1'b1, '0, 1'b1);
    check("t1_r3_data", 32'(ins_data), 32'h0A0003);
    step(1'b0, 1'b1, '0, 1'b1);
    check("t1_r3_alone", 32'(ins_valid), 32'd0);

    // Read-only stream: two-cycle latency, then one per cycle.
    step(1'b1, 1'b1, 25'h0B000A, 1'b1);
    check("t2_no_bypass", 32'(ins_valid), 32'd0);
    step(1'b1, 1'b1, 25'h0B000B, 1'b1);
    check("t2_a", 32'(ins_data), 32'h0B000A);
    step(1'b1, 1'b1, 25'h0B000C, 1'b1);
    check("t2_b", 32'(ins_data), 32'h0B000B);
    step(1'b0, 1'b1, '0, 1'b1);
    check("t2_c", 32'(ins_data), 32'h0B000C);
    idle(2);

    // Watermark: three queued writes pre-empt the two waiting reads.
    apply_reset();
    step(1'b1, 1'b1, 25'h0C0001, 1'b0);
    step(1'b1, 1'b0, 25'h1C0001, 1'b0);
    step(1'b1, 1'b0, 25'h1C0002, 1'b0);
    step(1'b1, 1'b0, 25'h1C0003, 1'b0);
    step(1'b1, 1'b1, 25'h0C0002, 1'b0);
    step(1'b1, 1'b1, 25'h0C0003, 1'b0);
    check("t3_r1_held", 32'(ins_data), 32'h0C0001);
    exp_seq = '{25'h1C0001, 25'h1C0002, 25'h1C0003, 25'h0C0002, 25'h0C0003};
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, '0, 1'b1);
      check($sformatf("t3_order%0d", i), 32'(ins_data), 32'(exp_seq[i]));
    end
    step(1'b0, 1'b1, '0, 1'b1);
    check("t3_empty", 32'(ins_valid), 32'd0);

    // Starvation: one write waits behind a steady read stream for exactly 8 reads.
    apply_reset();
    step(1'b1, 1'b1, 25'h0D0001, 1'b0);
    step(1'b1, 1'b1, 25'h0D0002, 1'b0);
    step(1'b1, 1'b0, 25'h1D0001, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 25'(32'h0D0003 + i), 1'b1);
      check($sformatf("t4_read%0d", i), 32'(ins_is_rd), 32'd1);
    end
    step(1'b1, 1'b1, 25'h0D0100, 1'b1);
    check("t4_w1_data", 32'(ins_data), 32'h1D0001);
    check("t4_w1_is_wr", 32'(ins_is_rd), 32'd0);
    idle(6);

    // Full read queue blocks reads only; one pop reopens it.
    apply_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 25'(32'h0E0000 + i), 1'b0);
    req_valid = 1'b0;
    req_is_rd = 1'b1;
    #1;
    check("t5_rd_full_ready", 32'(req_ready), 32'd0);
    check("t5_rd_count", 32'(rd_count), 32'd4);
    req_is_rd = 1'b0;
    #1;
    check("t5_wr_ready", 32'(req_ready), 32'd1);
    step(1'b0, 1'b1, '0, 1'b1);
    check("t5_reopen", 32'(req_ready), 32'd1);
    idle(6);

    // Writes with no reads are served in READ mode without touching starvation.
    apply_reset();
    step(1'b1, 1'b0, 25'h1F0001, 1'b1);
    step(1'b1, 1'b0, 25'h1F0002, 1'b1);
    check("t6_w1", 32'(ins_data), 32'h1F0001);
    check("t6_mode1", 32'(dut.mode), 32'(READ));
    step(1'b0, 1'b1, '0, 1'b1);
    check("t6_w2", 32'(ins_data), 32'h1F0002);
    check("t6_mode2", 32'(dut.mode), 32'(READ));
    check("t6_starve", 32'(dut.starve_cnt), 32'd0);
    idle(2);

    // Random traffic with alternating light and heavy back-pressure.
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      int rdy_pct = ((i / 40) % 2 == 1) ? 25 : 85;
      step($urandom_range(0, 99) < 65, 1'($urandom), 25'($urandom),
           $urandom_range(0, 99) < rdy_pct);
    end
    idle(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
